cfg_table_seq: RTL and testbench

CFG_TABLE_SEQ -- requirements
Module: cfg_table_seq

---
 rtl/cfg_pkg.sv | 49 ++++
 rtl/cfg_table_rom.sv | 36 +++
 rtl/cfg_table_seq.sv | 168 ++++++++++++++++
 tb/tb_cfg_table_seq.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the configuration-table sequencer: FSM states,
// table entry layout and SPI instruction-word field positions.
package cfg_pkg;

   localparam int WORD_W        = 24;
   localparam int WORD_RNW_BIT  = 23;
   localparam int WORD_LEN_LSB  = 21;
   localparam int WORD_ADDR_LSB = 8;
   localparam int WORD_DATA_LSB = 0;
   localparam int CFG_ADDR_W    = 13;
   localparam int CFG_DATA_W    = 8;

   localparam logic [CFG_ADDR_W-1:0] TRANSFER_ADDR = 13'h0FF;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR,
      S_WR_ACK,
      S_WR_FIN,
      S_RD,
      S_RD_ACK,
      S_RD_FIN,
      S_CHECK,
      S_NEXT,
      S_DONE,
      S_ERR
   } cfg_state_e;

   typedef struct packed {
      logic                  verify;
      logic [CFG_ADDR_W-1:0] addr;
      logic [CFG_DATA_W-1:0] data;
   } cfg_entry_t;

   // Single-byte instruction word; reads always carry a zero data byte.
   function automatic logic [WORD_W-1:0] cfg_word(input logic                  rnw,
                                                  input logic [CFG_ADDR_W-1:0] addr,
                                                  input logic [CFG_DATA_W-1:0] data);
      logic [WORD_W-1:0] w;
      w                                = '0;
      w[WORD_RNW_BIT]                  = rnw;
      w[WORD_LEN_LSB +: 2]             = 2'b00;
      w[WORD_ADDR_LSB +: CFG_ADDR_W]   = addr;
      w[WORD_DATA_LSB +: CFG_DATA_W]   = rnw ? '0 : data;
      return w;
   endfunction

endpackage

// File: rtl/cfg_table_rom.sv
`timescale 1ns/1ps
// Constant register table: combinational index -> {verify, addr, data}.
// The final entry is always the transfer-register write that commits the set.
module cfg_table_rom
   import cfg_pkg::*;
#(
   parameter int TABLE_DEPTH = 16,
   parameter int IDX_W       = $clog2(TABLE_DEPTH)
) (
   input  logic [IDX_W-1:0] i_idx,
   output cfg_entry_t       o_entry
);

   always_comb begin
      o_entry = '{verify: 1'b0, addr: TRANSFER_ADDR, data: 8'h01};
      case (int'(i_idx))
         0:       o_entry = '{1'b1, 13'h000, 8'h18};
         1:       o_entry = '{1'b0, 13'h001, 8'h00};
         2:       o_entry = '{1'b1, 13'h010, 8'h7C};
         3:       o_entry = '{1'b1, 13'h011, 8'h05};
         4:       o_entry = '{1'b0, 13'h012, 8'h20};
         5:       o_entry = '{1'b1, 13'h013, 8'h3A};
         6:       o_entry = '{1'b1, 13'h014, 8'h0F};
         7:       o_entry = '{1'b0, 13'h015, 8'h44};
         8:       o_entry = '{1'b1, 13'h016, 8'h81};
         9:       o_entry = '{1'b1, 13'h017, 8'h00};
         10:      o_entry = '{1'b0, 13'h018, 8'h5A};
         11:      o_entry = '{1'b1, 13'h019, 8'hA5};
         12:      o_entry = '{1'b1, 13'h01A, 8'h33};
         13:      o_entry = '{1'b0, 13'h01B, 8'hC0};
         14:      o_entry = '{1'b1, 13'h020, 8'h02};
         default: o_entry = '{1'b0, TRANSFER_ADDR, 8'h01};
      endcase
   end

endmodule

// File: rtl/cfg_table_seq.sv
`timescale 1ns/1ps
// Configuration table sequencer: on a start edge, writes every ROM entry through the
// shared SPI master, reads back entries marked verify, retries, and reports done/err.
module cfg_table_seq
   import cfg_pkg::*;
#(
   parameter int MOSI_DATA_WIDTH = 24,
   parameter int MISO_DATA_WIDTH = 8,
   parameter int TABLE_DEPTH     = 16,
   parameter int MAX_RETRY       = 3,
   parameter int TIMEOUT_CYC     = 4096
) (
   input  logic                           clk_20,
   input  logic                           rst,
   input  logic                           i_cfg_start,
   output logic                           o_cfg_go,
   output logic                           o_cfg_done,
   output logic                           o_cfg_err,
   output logic [$clog2(TABLE_DEPTH)-1:0] o_err_idx,
   output logic                           o_spi_wr_cmd,
   output logic                           o_spi_rd_cmd,
   output logic [MOSI_DATA_WIDTH-1:0]     o_spi_wr_data,
   input  logic [MISO_DATA_WIDTH-1:0]     i_spi_rd_data,
   input  logic                           i_spi_busy
);

   localparam int IDX_W   = $clog2(TABLE_DEPTH);
   localparam int RETRY_W = $clog2(MAX_RETRY) + 1;
   localparam int TMO_W   = $clog2(TIMEOUT_CYC) + 1;

   cfg_state_e                 state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [RETRY_W-1:0]         retry_q, retry_d;
   logic [TMO_W-1:0]           tmo_q, tmo_d;
   logic                       start_q;
   logic [MISO_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                       start_rise;
   logic                       tmo_hit;
   logic                       wr_cmd, rd_cmd;
   logic [WORD_W-1:0]          word;
   cfg_entry_t                 entry;

   cfg_table_rom #(
      .TABLE_DEPTH(TABLE_DEPTH),
      .IDX_W      (IDX_W)
   ) u_rom (
      .i_idx  (idx_q),
      .o_entry(entry)
   );

   assign start_rise = i_cfg_start & ~start_q;
   assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk_20) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         retry_q <= '0;
         tmo_q   <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         retry_q <= retry_d;
         tmo_q   <= tmo_d;
         start_q <= i_cfg_start;
      end
      rd_data_q <= rd_data_d;
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      retry_d   = retry_q;
      tmo_d     = tmo_q;
      rd_data_d = rd_data_q;
      wr_cmd    = 1'b0;
      rd_cmd    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_rise) begin
               idx_d   = '0;
               retry_d = '0;
               state_d = S_WR;
            end
         end
         // Commands only launch onto an idle bus; the pulse coincides with the exit.
         S_WR: begin
            if (!i_spi_busy) begin
               wr_cmd  = 1'b1;
               tmo_d   = '0;
               state_d = S_WR_ACK;
            end
         end
         S_WR_ACK: begin
            if (i_spi_busy) begin
               tmo_d   = '0;
               state_d = S_WR_FIN;
            end else if (tmo_hit) state_d = S_ERR;
            else                  tmo_d   = tmo_q + TMO_W'(1);
         end
         S_WR_FIN: begin
            if (!i_spi_busy)  state_d = entry.verify ? S_RD : S_NEXT;
            else if (tmo_hit) state_d = S_ERR;
            else              tmo_d   = tmo_q + TMO_W'(1);
         end
         S_RD: begin
            if (!i_spi_busy) begin
               rd_cmd  = 1'b1;
               tmo_d   = '0;
               state_d = S_RD_ACK;
            end
         end
         S_RD_ACK: begin
            if (i_spi_busy) begin
               tmo_d   = '0;
               state_d = S_RD_FIN;
            end else if (tmo_hit) state_d = S_ERR;
            else                  tmo_d   = tmo_q + TMO_W'(1);
         end
         S_RD_FIN: begin
            if (!i_spi_busy) begin
               rd_data_d = i_spi_rd_data;
               state_d   = S_CHECK;
            end else if (tmo_hit) state_d = S_ERR;
            else                  tmo_d   = tmo_q + TMO_W'(1);
         end
         S_CHECK: begin
            if (rd_data_q == MISO_DATA_WIDTH'(entry.data)) state_d = S_NEXT;
            else if (retry_q < RETRY_W'(MAX_RETRY - 1)) begin
               retry_d = retry_q + RETRY_W'(1);
               state_d = S_WR;
            end else state_d = S_ERR;
         end
         S_NEXT: begin
            retry_d = '0;
            if (idx_q == IDX_W'(TABLE_DEPTH - 1)) state_d = S_DONE;
            else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_WR;
            end
         end
         S_DONE, S_ERR: begin
            if (!i_cfg_start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The word follows the current entry from the command cycle until the _FIN exit.
   always_comb begin
      word = '0;
      case (state_q)
         S_WR, S_WR_ACK, S_WR_FIN: word = cfg_word(1'b0, entry.addr, entry.data);
         S_RD, S_RD_ACK, S_RD_FIN: word = cfg_word(1'b1, entry.addr, entry.data);
         default:                  word = '0;
      endcase
   end

   assign o_spi_wr_data = MOSI_DATA_WIDTH'(word);
   assign o_spi_wr_cmd  = wr_cmd;
   assign o_spi_rd_cmd  = rd_cmd;
   assign o_cfg_go      = !(state_q inside {S_IDLE, S_DONE, S_ERR});
   assign o_cfg_done    = (state_q == S_DONE);
   assign o_cfg_err     = (state_q == S_ERR);
   assign o_err_idx     = (state_q == S_ERR) ? idx_q : '0;

endmodule

// File: tb/tb_cfg_table_seq.sv
`timescale 1ns/1ps
// Bench for cfg_table_seq: echoing SPI slave model, command scoreboard built from the
// register table, and directed scenarios (normal, retry, retry exhaustion, reset, timeout).
module tb_cfg_table_seq;

   localparam int DEPTH = 16;
   localparam int MAXR  = 3;
   localparam int TMO   = 4096;

   logic        clk_20 = 1'b0;
   logic        rst;
   logic        i_cfg_start;
   logic        o_cfg_go, o_cfg_done, o_cfg_err;
   logic [3:0]  o_err_idx;
   logic        o_spi_wr_cmd, o_spi_rd_cmd;
   logic [23:0] o_spi_wr_data;
   logic [7:0]  i_spi_rd_data;
   logic        i_spi_busy;

   always #25 clk_20 = ~clk_20;

   cfg_table_seq #(
      .MOSI_DATA_WIDTH(24),
      .MISO_DATA_WIDTH(8),
      .TABLE_DEPTH    (DEPTH),
      .MAX_RETRY      (MAXR),
      .TIMEOUT_CYC    (TMO)
   ) dut (
      .clk_20       (clk_20),
      .rst          (rst),
      .i_cfg_start  (i_cfg_start),
      .o_cfg_go     (o_cfg_go),
      .o_cfg_done   (o_cfg_done),
      .o_cfg_err    (o_cfg_err),
      .o_err_idx    (o_err_idx),
      .o_spi_wr_cmd (o_spi_wr_cmd),
      .o_spi_rd_cmd (o_spi_rd_cmd),
      .o_spi_wr_data(o_spi_wr_data),
      .i_spi_rd_data(i_spi_rd_data),
      .i_spi_busy   (i_spi_busy)
   );

   // Register table as loaded into the design's ROM.
   bit          t_ver  [DEPTH] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 0};
   logic [12:0] t_addr [DEPTH] = '{13'h000, 13'h001, 13'h010, 13'h011, 13'h012, 13'h013,
                                   13'h014, 13'h015, 13'h016, 13'h017, 13'h018, 13'h019,
                                   13'h01A, 13'h01B, 13'h020, 13'h0FF};
   logic [7:0]  t_data [DEPTH] = '{8'h18, 8'h00, 8'h7C, 8'h05, 8'h20, 8'h3A, 8'h0F, 8'h44,
                                   8'h81, 8'h00, 8'h5A, 8'hA5, 8'h33, 8'hC0, 8'h02, 8'h01};

   int          n_assert = 0;
   int          n_fail   = 0;
   int          mode     = 0;   // 0 clean, 1 entry-3 glitch once, 2 entry-5 always bad, 3 bus dead
   bit          glitch_used;
   bit          exp_err;
   int          exp_idx;
   logic [23:0] exp_q[$];
   logic [23:0] log_q[$];
   logic [7:0]  mem [0:8191];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [23:0] mk_word(input bit rnw, input logic [12:0] a, input logic [7:0] d);
      return {rnw, 2'b00, a, (rnw ? 8'h00 : d)};
   endfunction

   // Expected command stream and outcome for a full table run under a given fault mode.
   task automatic build_expected(input int m);
      bit         used;
      bit         ok;
      logic [7:0] rv;
      used = 0;
      exp_q.delete();
      exp_err = 0;
      exp_idx = 0;
      for (int i = 0; i < DEPTH; i++) begin
         ok = 0;
         for (int a = 0; a < MAXR && !ok; a++) begin
            exp_q.push_back(mk_word(1'b0, t_addr[i], t_data[i]));
            if (!t_ver[i]) ok = 1;
            else begin
               exp_q.push_back(mk_word(1'b1, t_addr[i], 8'h00));
               rv = t_data[i];
               if (m == 1 && i == 3 && !used) begin
                  rv   = 8'h00;
                  used = 1;
               end
               if (m == 2 && i == 5) rv = ~t_data[i];
               ok = (rv == t_data[i]);
            end
         end
         if (!ok) begin
            exp_err = 1;
            exp_idx = i;
            break;
         end
      end
   endtask

   function automatic logic [23:0] log_at(input int i);
      if (i < log_q.size()) return log_q[i];
      return 24'hxxxxxx;
   endfunction

   function automatic int count_word(input int base, input logic [23:0] w);
      int n = 0;
      for (int i = base; i < log_q.size(); i++) if (log_q[i] == w) n++;
      return n;
   endfunction

   function automatic int count_kind(input int base, input bit rnw);
      int n = 0;
      for (int i = base; i < log_q.size(); i++) if (log_q[i][23] == rnw) n++;
      return n;
   endfunction

   // SPI slave model plus per-cycle compare against the scoreboard, sampled on negedge.
   initial begin : spi_model
      int          pend;
      int          bcnt;
      logic [23:0] cur;
      logic [23:0] last;
      logic [7:0]  rd;
      pend = 0;
      bcnt = 0;
      cur  = '0;
      last = '0;
      i_spi_busy    = 1'b0;
      i_spi_rd_data = 8'h00;
      for (int k = 0; k < 8192; k++) mem[k] = 8'h00;
      forever begin
         @(negedge clk_20);
         if (!rst) begin
            check("done_err_excl", 32'(o_cfg_done && o_cfg_err), 32'd0);
            if (!o_cfg_err) check("err_idx_zero", 32'(o_err_idx), 32'd0);
            if (o_cfg_done || o_cfg_err) check("go_released", 32'(o_cfg_go), 32'd0);
            if (o_cfg_go && (pend > 0 || i_spi_busy)) check("wr_data_stable", 32'(o_spi_wr_data), 32'(last));
            if (o_spi_wr_cmd || o_spi_rd_cmd) begin
               check("cmd_single", 32'(o_spi_wr_cmd && o_spi_rd_cmd), 32'd0);
               check("cmd_go", 32'(o_cfg_go), 32'd1);
               check("cmd_bus_idle", 32'(i_spi_busy || pend > 0), 32'd0);
               check("cmd_kind", 32'(o_spi_wr_data[23]), 32'(o_spi_rd_cmd));
               if (exp_q.size() == 0) begin
                  n_assert++;
                  n_fail++;
                  $display("FAIL cmd_unexpected: got word 0x%06h required no command", o_spi_wr_data);
               end else check("cmd_word", 32'(o_spi_wr_data), 32'(exp_q.pop_front()));
               log_q.push_back(o_spi_wr_data);
               last = o_spi_wr_data;
            end
         end
         if (!rst && (o_spi_wr_cmd || o_spi_rd_cmd) && mode != 3) begin
            pend = 2;
            cur  = o_spi_wr_data;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               i_spi_busy = 1'b1;
               bcnt       = 40;
            end
         end else if (i_spi_busy) begin
            bcnt--;
            if (bcnt == 0) begin
               i_spi_busy = 1'b0;
               if (!cur[23]) mem[cur[20:8]] = cur[7:0];
               else begin
                  rd = mem[cur[20:8]];
                  if (mode == 1 && cur[20:8] == 13'h011 && !glitch_used) begin
                     rd          = 8'h00;
                     glitch_used = 1;
                  end
                  if (mode == 2 && cur[20:8] == 13'h013) rd = ~rd;
                  i_spi_rd_data = rd;
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_20);
      #1;
   endtask

   task automatic wait_end(input int bound, input string name);
      int k = 0;
      while (!(o_cfg_done || o_cfg_err) && k < bound) begin
         tick(1);
         k++;
      end
      if (!(o_cfg_done || o_cfg_err)) begin
         n_assert++;
         n_fail++;
         $display("FAIL %s_timeout: no done/err within %0d cycles", name, bound);
      end
   endtask

   task automatic check_outcome(input string name);
      check({name, "_done"}, 32'(o_cfg_done), 32'(!exp_err));
      check({name, "_err"}, 32'(o_cfg_err), 32'(exp_err));
      check({name, "_err_idx"}, 32'(o_err_idx), 32'(exp_idx));
      check({name, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_go"}, 32'(o_cfg_go), 32'd0);
      check({name, "_done"}, 32'(o_cfg_done), 32'd0);
      check({name, "_err"}, 32'(o_cfg_err), 32'd0);
      check({name, "_err_idx"}, 32'(o_err_idx), 32'd0);
      check({name, "_wr_cmd"}, 32'(o_spi_wr_cmd), 32'd0);
      check({name, "_rd_cmd"}, 32'(o_spi_rd_cmd), 32'd0);
      check({name, "_wr_data"}, 32'(o_spi_wr_data), 32'd0);
   endtask

   initial begin : watchdog
      #(60000 * 50);
      $display("FAIL watchdog: simulation exceeded 60000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int base;
      int k;
      rst         = 1'b1;
      i_cfg_start = 1'b0;
      glitch_used = 0;
      tick(3);
      check_all_zero("reset");
      rst = 1'b0;
      tick(2);
      check_all_zero("idle");

      // Clean run: 16 writes, 10 verify reads.
      mode = 0;
      build_expected(0);
      check("model_clean_len", 32'(exp_q.size()), 32'd26);
      base = log_q.size();
      i_cfg_start = 1'b1;
      wait_end(3000, "clean");
      check_outcome("clean");
      check("clean_done_lit", 32'(o_cfg_done), 32'd1);
      check("clean_nwords", 32'(log_q.size() - base), 32'd26);
      check("clean_nwrites", 32'(count_kind(base, 1'b0)), 32'd16);
      check("clean_nreads", 32'(count_kind(base, 1'b1)), 32'd10);
      check("clean_w0", 32'(log_at(base + 0)), 32'h000018);
      check("clean_r0", 32'(log_at(base + 1)), 32'h800000);
      check("clean_w1", 32'(log_at(base + 2)), 32'h000100);
      check("clean_r2", 32'(log_at(base + 4)), 32'h801000);
      check("clean_w15", 32'(log_at(base + 25)), 32'h00FF01);

      // Start held high through DONE: no retrigger.
      base = log_q.size();
      tick(100);
      check("hold_done", 32'(o_cfg_done), 32'd1);
      check("hold_no_cmds", 32'(log_q.size() - base), 32'd0);
      i_cfg_start = 1'b0;
      tick(2);
      check("hold_release_done", 32'(o_cfg_done), 32'd0);
      check("hold_release_go", 32'(o_cfg_go), 32'd0);
      build_expected(0);
      base = log_q.size();
      i_cfg_start = 1'b1;
      wait_end(3000, "rerun");
      check_outcome("rerun");
      check("rerun_nwords", 32'(log_q.size() - base), 32'd26);
      check("rerun_w0", 32'(log_at(base)), 32'h000018);
      i_cfg_start = 1'b0;
      tick(3);

      // Single readback glitch on entry 3.
      mode        = 1;
      glitch_used = 0;
      build_expected(1);
      check("model_glitch_len", 32'(exp_q.size()), 32'd28);
      base = log_q.size();
      i_cfg_start = 1'b1;
      wait_end(3000, "glitch");
      check_outcome("glitch");
      check("glitch_done_lit", 32'(o_cfg_done), 32'd1);
      check("glitch_nwords", 32'(log_q.size() - base), 32'd28);
      check("glitch_e3_writes", 32'(count_word(base, 24'h001105)), 32'd2);
      check("glitch_rewrite", 32'(log_at(base + 7)), 32'h001105);
      check("glitch_reread", 32'(log_at(base + 8)), 32'h801100);
      i_cfg_start = 1'b0;
      tick(3);

      // Entry 5 never verifies: retries exhausted.
      mode = 2;
      build_expected(2);
      check("model_bad_len", 32'(exp_q.size()), 32'd14);
      check("model_bad_idx", 32'(exp_idx), 32'd5);
      base = log_q.size();
      i_cfg_start = 1'b1;
      wait_end(3000, "bad5");
      check_outcome("bad5");
      check("bad5_err_lit", 32'(o_cfg_err), 32'd1);
      check("bad5_idx_lit", 32'(o_err_idx), 32'd5);
      check("bad5_go", 32'(o_cfg_go), 32'd0);
      check("bad5_e5_writes", 32'(count_word(base, 24'h00133A)), 32'd3);
      check("bad5_e5_reads", 32'(count_word(base, 24'h801300)), 32'd3);
      check("bad5_no_e6", 32'(count_word(base, 24'h00140F)), 32'd0);
      i_cfg_start = 1'b0;
      tick(3);
      check("bad5_release", 32'(o_cfg_err), 32'd0);

      // Reset during RD_ACK of entry 2.
      mode = 0;
      build_expected(0);
      i_cfg_start = 1'b1;
      k = 0;
      while (!(o_spi_rd_cmd && o_spi_wr_data == 24'h801000) && k < 2000) begin
         tick(1);
         k++;
      end
      check("rst_reached_rd2", 32'(o_spi_rd_cmd && o_spi_wr_data == 24'h801000), 32'd1);
      tick(1);
      rst         = 1'b1;
      i_cfg_start = 1'b0;
      tick(1);
      check_all_zero("midrst");
      rst  = 1'b0;
      base = log_q.size();
      tick(60);
      check("midrst_no_cmds", 32'(log_q.size() - base), 32'd0);
      check("midrst_go", 32'(o_cfg_go), 32'd0);
      build_expected(0);
      base = log_q.size();
      i_cfg_start = 1'b1;
      wait_end(3000, "restart");
      check_outcome("restart");
      check("restart_w0", 32'(log_at(base)), 32'h000018);
      check("restart_nwords", 32'(log_q.size() - base), 32'd26);
      i_cfg_start = 1'b0;
      tick(3);

      // Bus never goes busy: WR_ACK timeout.
      mode = 3;
      build_expected(3);
      i_cfg_start = 1'b1;
      k = 0;
      while (!o_spi_wr_cmd && k < 50) begin
         tick(1);
         k++;
      end
      check("tmo_first_cmd", 32'(o_spi_wr_cmd), 32'd1);
      k = 0;
      while (!o_cfg_err && k < TMO + 20) begin
         tick(1);
         k++;
      end
      check("tmo_latency", 32'(k - 1), 32'(TMO));
      check("tmo_err", 32'(o_cfg_err), 32'd1);
      check("tmo_err_idx", 32'(o_err_idx), 32'd0);
      check("tmo_go", 32'(o_cfg_go), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
